// File: rtl/nist_stream_gen_if.sv
// ============================================================================
// Module      : nist_stream_gen_if
// Description : Control/stream bundle between a controller and nist_stream_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nist_stream_gen_if #(
    parameter int BURST_W = 20
);
    logic               start;
    logic               stop;
    logic [2:0]         mode;
    logic [15:0]        seed;
    logic [BURST_W-1:0] burst_len;
    logic               RND_out;
    logic               valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, seed, burst_len,
        input  RND_out, valid, busy, done
    );

    modport slave (
        input  start, stop, mode, seed, burst_len,
        output RND_out, valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/nist_stream_gen.sv
// ============================================================================
// Module      : nist_stream_gen
// Description : Pattern/LFSR bit-stream generator with burst and stop control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nist_stream_gen #(
    parameter int          BURST_W      = 20,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    nist_stream_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [BURST_W-1:0] c_CNT_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] c_CNT_MAX = {BURST_W{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_mode;
    logic [15:0]        r_seed;
    logic [BURST_W-1:0] r_len;
    logic [BURST_W-1:0] r_cnt;
    logic [2:0]         r_sub;
    logic [15:0]        r_lfsr;
    logic               r_rnd;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_fb;
    logic [15:0]        w_shift;
    logic [15:0]        w_rot;
    logic               w_last;
    logic               w_bit;

    assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_shift = {w_fb, r_lfsr[15:1]};
    assign w_rot   = {r_lfsr[0], r_lfsr[15:1]};
    // The bit emitted this cycle is the Nth one when the pre-increment count is N-1.
    assign w_last  = (r_len != '0) && (r_cnt == (r_len - c_CNT_ONE));

    always_comb begin
        w_bit = 1'b0;
        unique case (r_mode)
            3'd1:    w_bit = 1'b0;
            3'd2:    w_bit = 1'b1;
            3'd3:    w_bit = ~r_sub[0];
            3'd4:    w_bit = r_lfsr[0] | r_lfsr[1];
            default: w_bit = r_lfsr[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SEED;
            S_SEED:  w_next = S_RUN;
            S_RUN:   if (bus.stop || w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 3'd0;
            r_seed  <= 16'd0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_sub   <= 3'd0;
            r_lfsr  <= SEED_DEFAULT;
            r_rnd   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rnd   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= (r_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_seed <= bus.seed;
                        r_len  <= bus.burst_len;
                    end
                end
                S_SEED: begin
                    r_lfsr <= (r_seed == 16'd0) ? SEED_DEFAULT : r_seed;
                    r_cnt  <= '0;
                    r_sub  <= 3'd0;
                end
                S_RUN: begin
                    r_valid <= 1'b1;
                    r_rnd   <= w_bit;
                    r_sub   <= r_sub + 3'd1;
                    if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_ONE;
                    unique case (r_mode)
                        3'd1, 3'd2, 3'd3: r_lfsr <= r_lfsr;
                        3'd5:             if (r_sub == 3'd7) r_lfsr <= w_shift;
                        3'd6:             r_lfsr <= w_rot;
                        default:          r_lfsr <= w_shift;
                    endcase
                end
                S_DONE: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.RND_out = r_rnd;
    assign bus.valid   = r_valid;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nist_stream_gen.sv
// ============================================================================
// Module      : tb_nist_stream_gen
// Description : Self-checking bench for nist_stream_gen (table + random bursts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nist_stream_gen;

    localparam int          BW   = 20;
    localparam logic [15:0] SDEF = 16'hACE1;

    typedef struct {
        logic [2:0]    mode;
        logic [15:0]   seed;
        logic [BW-1:0] len;
        int            stop_at;
        int            repulse_at;
        int            exp_n;
        logic          has_pat;
        logic [31:0]   exp_bits;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nist_stream_gen_if #(.BURST_W(BW)) bus ();

    nist_stream_gen #(.BURST_W(BW), .SEED_DEFAULT(SDEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Bit i of a burst, straight from the pattern rules.
    function automatic logic ref_bit(input logic [2:0] m, input logic [15:0] s, input int i);
        logic [15:0] l;
        int          steps;
        l = (s == 16'd0) ? SDEF : s;
        case (m)
            3'd1: return 1'b0;
            3'd2: return 1'b1;
            3'd3: return (i % 2) == 0;
            3'd6: return l[i % 16];
            default: begin
                steps = (m == 3'd5) ? i / 8 : i;
                for (int k = 0; k < steps; k++) l = lfsr_next(l);
                return (m == 3'd4) ? (l[0] | l[1]) : l[0];
            end
        endcase
    endfunction

    task automatic run_burst(input vec_t v);
        logic q[$];
        int   edges = 0;
        int   first = -1;
        int   ndone = 0;
        int   bad_rnd = 0;
        int   bad_busy = 0;
        int   post = -1;
        int   limit;
        int   mm = 0;
        int   pm = 0;
        limit = ((v.len == '0) ? v.stop_at : int'(v.len)) + 40;
        @(negedge clk);
        bus.mode = v.mode; bus.seed = v.seed; bus.burst_len = v.len;
        bus.start = 1'b1; bus.stop = 1'b0;
        @(negedge clk);
        edges = 1;
        bus.start     = 1'b0;
        bus.mode      = 3'($urandom_range(0, 7));
        bus.seed      = 16'($urandom);
        bus.burst_len = BW'($urandom_range(1, 5));
        while (edges < limit && post != 0) begin
            @(negedge clk);
            edges++;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (bus.valid) begin
                q.push_back(bus.RND_out);
                if (first < 0) first = edges - 1;
            end else if (bus.RND_out !== 1'b0) begin
                bad_rnd++;
            end
            if ((bus.valid || bus.done) && !bus.busy) bad_busy++;
            if (bus.done) begin
                ndone++;
                if (post < 0) post = 3;
            end else if (post > 0) begin
                if (bus.busy) bad_busy++;
                post--;
            end
            if (v.stop_at != 0 && q.size() == v.stop_at - 1 && bus.valid) bus.stop = 1'b1;
            if (v.repulse_at != 0 && q.size() == v.repulse_at && bus.valid) bus.start = 1'b1;
        end
        for (int i = 0; i < q.size(); i++)
            if (q[i] !== ref_bit(v.mode, v.seed, i)) mm++;
        if (v.has_pat)
            for (int i = 0; i < q.size() && i < 32 && i < v.exp_n; i++)
                if (q[i] !== v.exp_bits[i]) pm++;
        check($sformatf("count m%0d len%0d", v.mode, v.len), 64'(q.size()), 64'(v.exp_n));
        check("done_pulses", 64'(ndone), 64'd1);
        check("first_valid_latency", 64'(first), 64'd2);
        check("rnd_zero_when_invalid", 64'(bad_rnd), 64'd0);
        check("busy_profile", 64'(bad_busy), 64'd0);
        check("model_bits", 64'(mm), 64'd0);
        if (v.has_pat) check("table_bits", 64'(pm), 64'd0);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   seen;
        int   extra;
        //           mode  seed      len  stop rep  exp_n pat   bits (LSB first)
        tbl[0] = '{3'd0, 16'h0001, 16, 0,   0,   16,  1'b1, 32'h0000_0001};
        tbl[1] = '{3'd0, 16'h0000, 4,  0,   0,   4,   1'b1, 32'h0000_0001};
        tbl[2] = '{3'd5, 16'h0001, 24, 0,   0,   24,  1'b1, 32'h0000_00FF};
        tbl[3] = '{3'd6, 16'h00FF, 32, 0,   10,  32,  1'b1, 32'h00FF_00FF};
        tbl[4] = '{3'd2, 16'h1234, 0,  100, 0,   100, 1'b1, 32'hFFFF_FFFF};
        tbl[5] = '{3'd1, 16'hBEEF, 20, 0,   0,   20,  1'b1, 32'h0000_0000};
        tbl[6] = '{3'd3, 16'h0000, 12, 0,   5,   12,  1'b1, 32'h0000_0555};
        tbl[7] = '{3'd4, 16'h0001, 8,  0,   0,   8,   1'b1, 32'h0000_0001};
        tbl[8] = '{3'd2, 16'h0000, 8,  8,   0,   8,   1'b1, 32'h0000_00FF};
        tbl[9] = '{3'd0, 16'h0000, 50, 6,   0,   6,   1'b1, 32'h0000_0021};

        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 3'd0; bus.seed = 16'd0; bus.burst_len = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(bus.valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_rnd", 64'(bus.RND_out), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_burst(tbl[i]);

        // Mid-burst reset: outputs drop at once, no done, then a fresh burst.
        @(negedge clk);
        bus.mode = 3'd3; bus.seed = 16'd0; bus.burst_len = BW'(10); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 5; c++) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
        check("reset_mid_reached_5", 64'(seen), 64'd5);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.valid), 64'd0);
        check("rst_async_rnd", 64'(bus.RND_out), 64'd0);
        check("rst_async_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid || bus.done || bus.busy) extra++;
        end
        check("post_reset_idle", 64'(extra), 64'd0);
        v = '{3'd3, 16'h0000, 4, 0, 0, 4, 1'b1, 32'h0000_0005};
        run_burst(v);

        for (int r = 0; r < 10; r++) begin
            v.mode       = 3'($urandom_range(0, 7));
            v.seed       = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            v.len        = BW'($urandom_range(1, 40));
            v.stop_at    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 45)) : 0;
            v.repulse_at = int'($urandom_range(0, 3));
            v.exp_n      = (v.stop_at != 0 && v.stop_at < int'(v.len)) ? v.stop_at : int'(v.len);
            v.has_pat    = 1'b0;
            v.exp_bits   = 32'd0;
            run_burst(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
